// File: rtl/cmp_pkg.sv
// Shared definitions for the registered magnitude comparator.
//   SLICE_W   : bit width handled by one cascadable compare stage
//   cmp_res_t : {gt, eq, lt} result bundle passed along the slice chain
//   n_slices  : number of slices needed to cover an operand of a given width
package cmp_pkg;

    localparam int SLICE_W = 4;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

    function automatic int n_slices(input int width);
        return (width + SLICE_W - 1) / SLICE_W;
    endfunction

endpackage

// File: rtl/comparator_slice.sv
// One 4-bit cascadable magnitude compare stage (unsigned).
//   a, b            : 4-bit operand nibbles for this stage
//   gt_in/eq_in/lt_in : result from the less-significant part of the operands
//   gt_out/eq_out/lt_out : result covering this nibble and everything below it
// A difference in this nibble decides the result outright; equal nibbles defer
// to the cascade inputs.
module comparator_slice
    import cmp_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               gt_in,
    input  logic               eq_in,
    input  logic               lt_in,
    output logic               gt_out,
    output logic               eq_out,
    output logic               lt_out
);

    always_comb begin
        gt_out = gt_in;
        eq_out = eq_in;
        lt_out = lt_in;
        if (a > b) begin
            gt_out = 1'b1;
            eq_out = 1'b0;
            lt_out = 1'b0;
        end else if (a < b) begin
            gt_out = 1'b0;
            eq_out = 1'b0;
            lt_out = 1'b1;
        end
    end

endmodule

// File: rtl/comparator.sv
// Registered N-bit magnitude comparator with a valid strobe.
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   in_valid, A, B  : operands, captured only on cycles with in_valid high
//   A_gt_B/A_eq_B/A_lt_B : registered one-hot compare result (all 0 after reset)
//   out_valid       : high for exactly the cycle after each accepted compare
//
// Valid semantics: there is no ready. Every edge with in_valid=1 (and rst=0)
// accepts A/B and presents the result with out_valid=1 on the next cycle. An
// edge with in_valid=0 drops out_valid and leaves the flags at their last
// value, so A/B are don't-care (even X) while in_valid is low. rst wins over
// in_valid and clears anything in flight.
module comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             A_gt_B,
    output logic             A_eq_B,
    output logic             A_lt_B,
    output logic             out_valid
);

    localparam int NSL   = n_slices(WIDTH);
    localparam int PAD_W = NSL * SLICE_W;

    logic [PAD_W-1:0] w_a_ext;
    logic [PAD_W-1:0] w_b_ext;
    cmp_res_t         w_chain [0:NSL];

    cmp_res_t         r_flags;
    logic             r_valid;

    // Zero-extend to a whole number of slices. For a signed compare, flipping
    // the sign bit maps -2^(W-1)..2^(W-1)-1 monotonically onto 0..2^W-1, so
    // the unsigned slice chain then yields the signed ordering.
    always_comb begin
        w_a_ext = '0;
        w_b_ext = '0;
        w_a_ext[WIDTH-1:0] = A;
        w_b_ext[WIDTH-1:0] = B;
        if (SIGNED != 0) begin
            w_a_ext[WIDTH-1] = ~A[WIDTH-1];
            w_b_ext[WIDTH-1] = ~B[WIDTH-1];
        end
    end

    // Below the least-significant slice the operands count as equal.
    assign w_chain[0] = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};

    for (genvar gi = 0; gi < NSL; gi++) begin : g_slice
        comparator_slice u_slice (
            .a      (w_a_ext[gi*SLICE_W +: SLICE_W]),
            .b      (w_b_ext[gi*SLICE_W +: SLICE_W]),
            .gt_in  (w_chain[gi].gt),
            .eq_in  (w_chain[gi].eq),
            .lt_in  (w_chain[gi].lt),
            .gt_out (w_chain[gi+1].gt),
            .eq_out (w_chain[gi+1].eq),
            .lt_out (w_chain[gi+1].lt)
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_flags <= w_chain[NSL];
            end
        end
    end

    assign A_gt_B    = r_flags.gt;
    assign A_eq_B    = r_flags.eq;
    assign A_lt_B    = r_flags.lt;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_comparator.sv
module tb_comparator;

  localparam int NDUT = 5;
  // instance configurations: 0:W4 unsigned, 1:W4 signed, 2:W6 unsigned,
  // 3:W6 signed, 4:W9 signed
  int w_of [NDUT] = '{4, 4, 6, 6, 9};
  int s_of [NDUT] = '{0, 1, 0, 1, 1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        drv_rst = 1'b1;
  logic        drv_valid = 1'b0;
  logic [15:0] drv_a = '0;
  logic [15:0] drv_b = '0;
  int          sel = 0;

  logic [NDUT-1:0] v_in;
  logic [NDUT-1:0] gt_o, eq_o, lt_o, ov_o;

  always_comb begin
    v_in = '0;
    v_in[sel] = drv_valid;
  end

  comparator #(.WIDTH(4), .SIGNED(0)) u_u4 (
    .clk(clk), .rst(drv_rst), .in_valid(v_in[0]), .A(drv_a[3:0]), .B(drv_b[3:0]),
    .A_gt_B(gt_o[0]), .A_eq_B(eq_o[0]), .A_lt_B(lt_o[0]), .out_valid(ov_o[0]));
  comparator #(.WIDTH(4), .SIGNED(1)) u_s4 (
    .clk(clk), .rst(drv_rst), .in_valid(v_in[1]), .A(drv_a[3:0]), .B(drv_b[3:0]),
    .A_gt_B(gt_o[1]), .A_eq_B(eq_o[1]), .A_lt_B(lt_o[1]), .out_valid(ov_o[1]));
  comparator #(.WIDTH(6), .SIGNED(0)) u_u6 (
    .clk(clk), .rst(drv_rst), .in_valid(v_in[2]), .A(drv_a[5:0]), .B(drv_b[5:0]),
    .A_gt_B(gt_o[2]), .A_eq_B(eq_o[2]), .A_lt_B(lt_o[2]), .out_valid(ov_o[2]));
  comparator #(.WIDTH(6), .SIGNED(1)) u_s6 (
    .clk(clk), .rst(drv_rst), .in_valid(v_in[3]), .A(drv_a[5:0]), .B(drv_b[5:0]),
    .A_gt_B(gt_o[3]), .A_eq_B(eq_o[3]), .A_lt_B(lt_o[3]), .out_valid(ov_o[3]));
  comparator #(.WIDTH(9), .SIGNED(1)) u_s9 (
    .clk(clk), .rst(drv_rst), .in_valid(v_in[4]), .A(drv_a[8:0]), .B(drv_b[8:0]),
    .A_gt_B(gt_o[4]), .A_eq_B(eq_o[4]), .A_lt_B(lt_o[4]), .out_valid(ov_o[4]));

  // observed word of the selected instance: {out_valid, gt, eq, lt}
  logic [3:0] obs;
  always_comb obs = {ov_o[sel], gt_o[sel], eq_o[sel], lt_o[sel]};

  // ---------------- reference model ----------------
  // Operands interpreted as mathematical integers, then ordered.
  function automatic longint to_int(input logic [15:0] v, input int w, input int sgn);
    longint x;
    x = 0;
    for (int i = 0; i < w; i++) if (v[i]) x += (longint'(1) << i);
    if (sgn != 0 && v[w-1]) x -= (longint'(1) << w);
    return x;
  endfunction

  function automatic logic [2:0] ref_cmp(input logic [15:0] a, input logic [15:0] b,
                                         input int w, input int sgn);
    longint va, vb;
    va = to_int(a, w, sgn);
    vb = to_int(b, w, sgn);
    if (va > vb) return 3'b100;
    if (va == vb) return 3'b010;
    return 3'b001;
  endfunction

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  logic [2:0] model_flags = 3'b000;
  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (sel=%0d)", tag, got, exp, sel);
    end
  endtask

  // ---------------- driver ----------------
  // One clock: apply inputs at negedge, predict, sample 1 time unit after posedge.
  task automatic cycle(input string tag, input logic r, input logic v,
                       input logic [15:0] a, input logic [15:0] b);
    logic [3:0] e;
    @(negedge clk);
    drv_rst = r;
    drv_valid = v;
    drv_a = a;
    drv_b = b;
    if (r) begin
      model_flags = 3'b000;
      exp_q.push_back(4'b0000);
    end else if (v) begin
      model_flags = ref_cmp(a, b, w_of[sel], s_of[sel]);
      exp_q.push_back({1'b1, model_flags});
    end else begin
      exp_q.push_back({1'b0, model_flags});
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val(tag, obs, e);
  endtask

  task automatic start_section(input int s);
    @(negedge clk);
    sel = s;
    cycle("reset", 1'b1, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic random_run(input string tag, input int n);
    logic [15:0] a, b;
    logic v, r;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = ($urandom_range(0, 7) == 0) ? a : 16'($urandom_range(0, 65535));
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 31) == 0);
      cycle(tag, r, v, a, b);
    end
  endtask

  task automatic exhaustive6(input string tag);
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        cycle(tag, 1'b0, 1'b1, 16'(a), 16'(b));
        check_val("onehot", {1'b0, 3'($countones({gt_o[sel], eq_o[sel], lt_o[sel]}))}, 4'd1);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // W4 unsigned: directed sequence
    sel = 0;
    cycle("reset0", 1'b1, 1'b0, 16'h0, 16'h0);
    cycle("reset1", 1'b1, 1'b0, 16'h0, 16'h0);
    cycle("zero_eq", 1'b0, 1'b1, 16'b0000, 16'b0000);
    cycle("b2b_gt", 1'b0, 1'b1, 16'b1010, 16'b1001);
    cycle("b2b_lt", 1'b0, 1'b1, 16'b0111, 16'b1111);
    cycle("b2b_eq", 1'b0, 1'b1, 16'b1100, 16'b1100);
    cycle("b2b_gt2", 1'b0, 1'b1, 16'b1000, 16'b0100);
    cycle("idle_hold", 1'b0, 1'b0, 16'b0000, 16'b1111);
    cycle("idle_x", 1'b0, 1'b0, 16'hxxxx, 16'hxxxx);
    cycle("min_max_u", 1'b0, 1'b1, 16'b0000, 16'b1111);
    cycle("rst_inflight", 1'b1, 1'b1, 16'b0111, 16'b1111);
    cycle("cap_lt", 1'b0, 1'b1, 16'b0111, 16'b1111);
    cycle("rst_after", 1'b1, 1'b0, 16'b0000, 16'b0000);
    cycle("post_rst_idle", 1'b0, 1'b0, 16'b0000, 16'b0000);
    random_run("rand_u4", 200);

    // W4 signed
    start_section(1);
    cycle("s_7_vs_m1", 1'b0, 1'b1, 16'b0111, 16'b1111);
    cycle("s_m8_vs_7", 1'b0, 1'b1, 16'b1000, 16'b0111);
    cycle("s_0_vs_m1", 1'b0, 1'b1, 16'b0000, 16'b1111);
    cycle("s_m8_eq", 1'b0, 1'b1, 16'b1000, 16'b1000);
    cycle("s_m1_vs_m8", 1'b0, 1'b1, 16'b1111, 16'b1000);
    random_run("rand_s4", 200);

    // W6 unsigned and signed, exhaustive
    start_section(2);
    exhaustive6("exh_u6");
    start_section(3);
    exhaustive6("exh_s6");

    // W9 signed, randomized
    start_section(4);
    cycle("s9_0_vs_m1", 1'b0, 1'b1, 16'h000, 16'h1ff);
    random_run("rand_s9", 600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
